uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter that serialises one parallel word per frame onto a single line, with configurable bit period, data width, parity and stop-bit count. It sits between the chain-code/image-processing output stage and the board serial pin. It replaces free-running one-bit-per-clock transmission with a baud-timed, flow-controlled valid/ready interface.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame; legal 1..2

- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- tx_data  in  DATA_BITS  word to send; sampled only on an accepting edge
- tx_valid  in  1  producer has a word on tx_data
- tx_ready  out  1  transmitter can accept a word this cycle
- tx_out  out  1  serial line; idles high
- tx_busy  out  1  high while a frame is on the line

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP. Internal registers:
  - shift register (DATA_BITS)
  - baud counter 0..CLKS_PER_BIT-1 ($clog2 width)
  - bit index 0..DATA_BITS-1
  - stop index 0..STOP_BITS-1
  - latched parity bit
- Accept: an edge with tx_valid && tx_ready high. On that edge:
  - latch tx_data
  - compute parity: even mode = XOR of data bits; odd mode = inverted XOR
  - go to START; tx_out <= 0; baud counter <= 0
- Each state holds for exactly CLKS_PER_BIT cycles. Advance when baud counter == CLKS_PER_BIT-1; the counter then clears.
- START -> DATA.
- DATA: transmit LSB first. After DATA_BITS bits, go to PAR if PARITY != 0, else go to STOP.
- PAR -> STOP.
- STOP: tx_out = 1 for STOP_BITS bit periods, then go to IDLE. If a word is accepted on that final edge, go directly to START instead.
- tx_ready is high in two cases:
  - state IDLE
  - last cycle of the last stop bit (state STOP, stop index == STOP_BITS-1, baud counter == CLKS_PER_BIT-1)
- tx_ready is forced low while reset is high.
- tx_busy = (state != IDLE).
- Changes on tx_data or tx_valid outside an accepting edge have no effect on the frame in flight.
- Illegal parameter values are an elaboration error (generate-time check).

## Timing
- Reset values (asynchronous, immediate): tx_out = 1, tx_ready = 0, tx_busy = 0, state IDLE, all counters 0.
- First cycle after reset deasserts: tx_ready = 1.
- Reset mid-frame: the frame is aborted and tx_out goes high immediately. No partial frame is resumed.
- Latency: the start bit appears on tx_out in the cycle after the accepting edge.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles. Default 8N1 at 16 = 160 cycles.
- Back-to-back: with tx_valid held high, the next start bit follows the last stop bit with zero idle cycles.
- tx_out is registered with no glitches. Each bit level is stable for exactly CLKS_PER_BIT cycles.
- tx_valid high while tx_ready is low: the word is not taken. The producer must hold it until accepted.

## Test plan
- Defaults, send 0xA5 once -> tx_out:
  - low for 16 cycles
  - then bits 1,0,1,0,0,1,0,1, 16 cycles each
  - then high for 16 cycles
  - tx_ready low for cycles 1..159 after accept; tx_busy high for 160 cycles
- PARITY = 2, DATA_BITS = 7, send 0x03 -> parity bit 0 after the 7 data bits. With PARITY = 1 -> parity bit 1. Frame = 10 bit periods.
- STOP_BITS = 2, tx_valid held high with 0x00 then 0xFF -> two stop periods (32 cycles high), then the next start bit with zero gap. Total 2 × 176 cycles.
- CLKS_PER_BIT = 2, send 0x81 -> each bit lasts exactly 2 cycles. Accept-to-IDLE takes 20 cycles.
- Assert reset at cycle 50 of a frame -> tx_out = 1 and tx_busy = 0 in the same cycle. After release:
  - tx_ready = 1 next cycle
  - a new word 0x5A transmits correctly with no residue from the aborted frame
- Change tx_data every cycle during a frame -> the transmitted bits match only the value latched at acceptance.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per frame over valid/ready and serialises it
// as start bit, DATA_BITS data bits (LSB first), optional parity bit, then stop bits.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy
);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
      $error("uart_tx_frame: illegal parameter value");
   end

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [SW-1:0]        stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_out_q, tx_out_d;
   logic                 baud_last;
   logic                 accept;

   // Ready is also open on the final stop cycle so a held tx_valid chains frames with no gap.
   assign tx_ready = ~reset & ((state_q == IDLE) |
                               ((state_q == STOP) & (stop_q == STOP_LAST) & (baud_q == BAUD_LAST)));
   assign accept   = tx_valid & tx_ready;
   assign tx_busy  = (state_q != IDLE);
   assign tx_out   = tx_out_q;

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      stop_d    = stop_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_out_d  = tx_out_q;
      baud_last = (baud_q == BAUD_LAST);

      if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + 1'b1;

      case (state_q)
         IDLE: tx_out_d = 1'b1;
         START: begin
            if (baud_last) begin
               state_d  = DATA;
               bit_d    = '0;
               tx_out_d = shift_q[0];
            end
         end
         DATA: begin
            if (baud_last) begin
               if (bit_q == BIT_LAST) begin
                  if (PARITY != 0) begin
                     state_d  = PAR;
                     tx_out_d = par_q;
                  end else begin
                     state_d  = STOP;
                     stop_d   = '0;
                     tx_out_d = 1'b1;
                  end
               end else begin
                  bit_d    = bit_q + 1'b1;
                  shift_d  = shift_q >> 1;
                  tx_out_d = shift_q[1];
               end
            end
         end
         PAR: begin
            if (baud_last) begin
               state_d  = STOP;
               stop_d   = '0;
               tx_out_d = 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               if (stop_q == STOP_LAST) begin
                  state_d  = IDLE;
                  tx_out_d = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
         end
      endcase

      // A word can only be taken in IDLE or on the last stop cycle, so it overrides both.
      if (accept) begin
         state_d  = START;
         baud_d   = '0;
         shift_d  = tx_data;
         par_d    = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
         tx_out_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_out_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_out_q <= tx_out_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameterisations share one clock/reset, a frame-level
// model predicts every output each cycle, and directed tests pin hand-computed bit levels.
module tb_uart_tx_frame;

   localparam int NI = 5;

   function automatic int p_cpb(input int g); return (g == 4) ? 2 : 16; endfunction
   function automatic int p_db (input int g); return (g == 1 || g == 2) ? 7 : 8; endfunction
   function automatic int p_par(input int g); return (g == 1) ? 2 : ((g == 2) ? 1 : 0); endfunction
   function automatic int p_sb (input int g); return (g == 3) ? 2 : 1; endfunction
   function automatic int flen (input int g);
      return 1 + p_db(g) + ((p_par(g) != 0) ? 1 : 0) + p_sb(g);
   endfunction

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] dat [NI];
   logic       vld [NI];
   logic       rdy [NI];
   logic       txo [NI];
   logic       bsy [NI];

   int pass = 0;
   int total = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_tx_frame #(
         .CLKS_PER_BIT(p_cpb(g)),
         .DATA_BITS   (p_db(g)),
         .PARITY      (p_par(g)),
         .STOP_BITS   (p_sb(g))
      ) u_dut (
         .clk     (clk),
         .reset   (rst),
         .tx_data (dat[g][p_db(g)-1:0]),
         .tx_valid(vld[g]),
         .tx_ready(rdy[g]),
         .tx_out  (txo[g]),
         .tx_busy (bsy[g])
      );
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- frame-level model ----------------
   logic        m_act [NI];
   int          m_cyc [NI];
   logic [12:0] m_bits[NI];

   initial for (int g = 0; g < NI; g++) begin
      m_act[g] = 1'b0; m_cyc[g] = 0; m_bits[g] = '1; vld[g] = 1'b0; dat[g] = '0;
   end

   // Whole frame as a bit list: start 0, data LSB first, optional parity, stop 1s.
   function automatic logic [12:0] frame_bits(input int g, input logic [8:0] d);
      logic [12:0] f;
      logic        x;
      f    = '1;
      f[0] = 1'b0;
      x    = 1'b0;
      for (int i = 0; i < p_db(g); i++) begin
         f[1+i] = d[i];
         x      = x ^ d[i];
      end
      if (p_par(g) != 0) f[1+p_db(g)] = (p_par(g) == 1) ? ~x : x;
      return f;
   endfunction

   function automatic logic exp_rdy(input int g);
      return !rst && (!m_act[g] || m_cyc[g] == flen(g) * p_cpb(g) - 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < NI; g++) begin
            m_act[g] <= 1'b0;
            m_cyc[g] <= 0;
         end
      end else begin
         for (int g = 0; g < NI; g++) begin
            if (vld[g] && exp_rdy(g)) begin
               m_act[g]  <= 1'b1;
               m_cyc[g]  <= 0;
               m_bits[g] <= frame_bits(g, dat[g]);
            end else if (m_act[g]) begin
               if (m_cyc[g] == flen(g) * p_cpb(g) - 1) begin
                  m_act[g] <= 1'b0;
                  m_cyc[g] <= 0;
               end else begin
                  m_cyc[g] <= m_cyc[g] + 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("model%0d_out", g), txo[g],
             m_act[g] ? m_bits[g][m_cyc[g] / p_cpb(g)] : 1'b1);
         chk($sformatf("model%0d_busy", g), bsy[g], m_act[g]);
         chk($sformatf("model%0d_ready", g), rdy[g], exp_rdy(g));
      end
   end

   // ---------------- directed stimulus ----------------
   // Returns just after the accepting edge; cycle 1 of the frame is the next negedge.
   task automatic send(input int g, input logic [8:0] d, input bit keep);
      bit got;
      got = 1'b0;
      @(negedge clk);
      dat[g] = d;
      vld[g] = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
         if (rdy[g]) got = 1'b1;
         else @(negedge clk);
      end
      chk($sformatf("send%0d_accepted", g), got, 1'b1);
      @(posedge clk);
      #1;
      if (!keep) vld[g] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] s_a5;
      logic [9:0] s_81;
      logic [9:0] s_5a;
      int         rdy_early;
      int         gap;
      s_a5 = 10'b1101001010;
      s_81 = 10'b1100000010;
      s_5a = 10'b1010110100;

      // reset state, then release
      @(negedge clk);
      chk("rst_out", txo[0], 1'b1);
      chk("rst_ready", rdy[0], 1'b0);
      chk("rst_busy", bsy[0], 1'b0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", rdy[0], 1'b1);

      // 8N1 at 16 clocks, 0xA5
      send(0, 9'h0A5, 1'b0);
      rdy_early = 0;
      for (int k = 1; k <= 161; k++) begin
         @(negedge clk);
         if (k <= 160) chk($sformatf("a5_out_c%0d", k), txo[0], s_a5[(k-1)/16]);
         if (k <= 159 && rdy[0]) rdy_early++;
         if (k == 160) begin
            chk("a5_ready_last", rdy[0], 1'b1);
            chk("a5_busy_last", bsy[0], 1'b1);
         end
         if (k == 161) chk("a5_busy_after", bsy[0], 1'b0);
      end
      chki("a5_ready_low_cycles", rdy_early, 0);

      // 7 data bits with even then odd parity, 0x03
      for (int g = 1; g <= 2; g++) begin
         send(g, 9'h003, 1'b0);
         for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            if (k == 129 || k == 144) chk($sformatf("par%0d_bit_c%0d", g, k), txo[g], (g == 2));
            if (k == 113) chk($sformatf("par%0d_d6", g), txo[g], 1'b0);
            if (k == 150) chk($sformatf("par%0d_stop", g), txo[g], 1'b1);
            if (k == 160) chk($sformatf("par%0d_busy_last", g), bsy[g], 1'b1);
            if (k == 161) chk($sformatf("par%0d_busy_after", g), bsy[g], 1'b0);
         end
      end

      // two stop bits, back-to-back 0x00 then 0xFF with tx_valid held
      send(3, 9'h000, 1'b1);
      dat[3] = 9'h0FF;
      gap = -1;
      for (int k = 1; k <= 400 && gap < 0; k++) begin
         @(negedge clk);
         if (k == 144) chk("s2_last_data", txo[3], 1'b0);
         if (k == 145) chk("s2_stop_start", txo[3], 1'b1);
         if (k == 176) chk("s2_stop_end", txo[3], 1'b1);
         if (rdy[3]) gap = k;
      end
      chki("s2_frame_len", gap, 176);
      @(posedge clk);
      #1;
      vld[3] = 1'b0;
      @(negedge clk);
      chk("s2_next_start", txo[3], 1'b0);
      chk("s2_next_busy", bsy[3], 1'b1);
      repeat (16) @(negedge clk);
      chk("s2_ff_bit0", txo[3], 1'b1);
      repeat (160) @(negedge clk);
      chk("s2_idle_after", bsy[3], 1'b0);

      // 2 clocks per bit, 0x81
      send(4, 9'h081, 1'b0);
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k <= 20) chk($sformatf("c2_out_c%0d", k), txo[4], s_81[(k-1)/2]);
         if (k == 20) chk("c2_ready_last", rdy[4], 1'b1);
         if (k == 21) chk("c2_busy_after", bsy[4], 1'b0);
      end

      // reset in the middle of a frame, then a clean 0x5A
      send(0, 9'h000, 1'b0);
      repeat (49) @(negedge clk);
      chk("abort_pre_out", txo[0], 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_out", txo[0], 1'b1);
      chk("abort_busy", bsy[0], 1'b0);
      chk("abort_ready", rdy[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready_release", rdy[0], 1'b1);
      send(0, 9'h05A, 1'b0);
      for (int k = 1; k <= 160; k++) begin
         @(negedge clk);
         chk($sformatf("5a_out_c%0d", k), txo[0], s_5a[(k-1)/16]);
      end

      // tx_data scrambled every cycle after accepting 0xC3
      send(0, 9'h0C3, 1'b0);
      for (int k = 1; k <= 161; k++) begin
         dat[0] = 9'($urandom);
         @(negedge clk);
         if (k == 17)  chk("c3_bit0", txo[0], 1'b1);
         if (k == 56)  chk("c3_bit2", txo[0], 1'b0);
         if (k == 100) chk("c3_bit5", txo[0], 1'b0);
         if (k == 129) chk("c3_bit7", txo[0], 1'b1);
         @(posedge clk);
         #1;
      end

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
